mem_store_buffer: RTL and testbench

//  Store buffer between the CPU load/store stage and the 256x8 data memory.

---
 rtl/mem_store_buffer_pkg.sv | 26 ++
 rtl/mem_store_buffer_if.sv | 37 +++
 rtl/mem_store_buffer_fwd_match.sv | 45 ++++
 rtl/mem_store_buffer.sv | 141 ++++++++++++++
 tb/tb_mem_store_buffer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// mem_sb_pkg
// Shared types and default sizing for the store buffer that sits between the
// CPU load/store stage and the 256x8 data memory.
//   sb_entry_t : one buffered store (valid flag, address, data)
//   mem_op_e   : data memory operation (read / write at posedge)
// -----------------------------------------------------------------------------
package mem_sb_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_AW     = 8;
  localparam int SB_DW     = 8;
  localparam int SB_STARVE = 4;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

endpackage

// File: rtl/mem_store_buffer_if.sv
// -----------------------------------------------------------------------------
// mem_store_buffer_if
// Bundles the CPU-side request/response signals and the data-memory port.
//   slave  : the store buffer's view (takes CPU requests, drives the memory)
//   master : the environment's view (CPU + data memory)
// Signals:
//   ldReq/stReq/cpuAddr/cpuWdata : CPU request
//   cpuRdata/stall/empty         : CPU response / status
//   memAddr/memDataIn/memOp      : to data memory
//   memDataOut                   : from data memory (combinational read)
// -----------------------------------------------------------------------------
interface mem_store_buffer_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          ldReq;
  logic          stReq;
  logic [AW-1:0] cpuAddr;
  logic [DW-1:0] cpuWdata;
  logic [DW-1:0] cpuRdata;
  logic          stall;
  logic          empty;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memDataIn;
  logic          memOp;
  logic [DW-1:0] memDataOut;

  modport slave (
    input  ldReq, stReq, cpuAddr, cpuWdata, memDataOut,
    output cpuRdata, stall, empty, memAddr, memDataIn, memOp
  );

  modport master (
    output ldReq, stReq, cpuAddr, cpuWdata, memDataOut,
    input  cpuRdata, stall, empty, memAddr, memDataIn, memOp
  );
endinterface

// File: rtl/mem_store_buffer_fwd_match.sv
// -----------------------------------------------------------------------------
// sb_fwd_match
// Combinational store-to-load forwarding search. Finds the youngest valid
// buffered entry whose address equals the load address.
// Ports:
//   entries : buffer contents
//   tail    : next write slot (slot after the youngest entry)
//   addr    : load address
//   hit     : a matching entry exists
//   data    : data of the youngest matching entry (0 when no hit)
// -----------------------------------------------------------------------------
module sb_fwd_match
  import mem_sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PW-1:0]    tail,
  input  logic [SB_AW-1:0] addr,
  output logic             hit,
  output logic [SB_DW-1:0] data
);

  logic [PW-1:0] idx_s;

  // Scan from the slot at tail (oldest) towards tail-1 (youngest); later hits
  // override earlier ones, so the youngest match wins.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    idx_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = tail + PW'(k);
      if (entries[idx_s].valid && (entries[idx_s].addr == addr)) begin
        hit  = 1'b1;
        data = entries[idx_s].data;
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// -----------------------------------------------------------------------------
// mem_store_buffer
// Store buffer in front of a single-port 256x8 data memory. Stores are queued
// in a FIFO and written back in cycles without a load; loads get the memory
// port first and are forwarded from the buffer on an address match. A starving
// buffer (STARVE consecutive lost cycles) forces a drain and stalls the load.
// Ports:
//   CLK   : clock, all state on posedge
//   reset : synchronous, active-high; discards buffered stores
//   bus   : mem_store_buffer_if.slave (CPU request/response + memory port)
// The entry struct is sized from the package, so AW/DW must keep their
// package defaults.
// -----------------------------------------------------------------------------
module mem_store_buffer
  import mem_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int AW     = SB_AW,
  parameter int DW     = SB_DW,
  parameter int STARVE = SB_STARVE
) (
  input logic                CLK,
  input logic                reset,
  mem_store_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE + 1);

  sb_entry_t     entries_q [DEPTH];
  sb_entry_t     entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          force_drain_s;
  logic          load_win_s;
  logic          pop_s;
  logic          push_s;
  logic          full_s;
  logic          hit_s;
  logic [DW-1:0] fwd_data_s;
  mem_op_e       mem_op_s;

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .entries (entries_q),
    .tail    (tail_q),
    .addr    (bus.cpuAddr),
    .hit     (hit_s),
    .data    (fwd_data_s)
  );

  // Port arbitration: loads win unless the buffer has starved long enough.
  // The write is suppressed during reset so discarded stores never land.
  always_comb begin
    force_drain_s = (starve_q == SW'(STARVE)) && (count_q != '0);
    load_win_s    = bus.ldReq && !force_drain_s;
    pop_s         = !reset && !load_win_s && (count_q != '0);
    full_s        = (count_q == CW'(DEPTH));
    push_s        = bus.stReq && (!full_s || pop_s);
    if (pop_s) begin
      mem_op_s = MEM_WRITE;
    end else begin
      mem_op_s = MEM_READ;
    end
  end

  assign bus.memOp     = mem_op_s;
  assign bus.memAddr   = pop_s ? entries_q[head_q].addr : bus.cpuAddr;
  assign bus.memDataIn = pop_s ? entries_q[head_q].data : '0;
  assign bus.stall     = (bus.stReq && full_s && !pop_s) || (bus.ldReq && force_drain_s);
  assign bus.empty     = (count_q == '0);
  // Forwarding reads pre-store state: a store pushed this cycle is not yet in entries_q.
  assign bus.cpuRdata  = hit_s ? fwd_data_s : bus.memDataOut;

  // FIFO and starvation counter next-state.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    starve_d  = starve_q;

    // Pop is applied before push so a full-buffer push into the slot being
    // drained keeps the new entry valid.
    if (pop_s) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end

    if (push_s) begin
      entries_d[tail_q] = '{valid: 1'b1, addr: bus.cpuAddr, data: bus.cpuWdata};
      tail_d            = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (count_q == '0) begin
      starve_d = '0;
    end else if (pop_s) begin
      starve_d = '0;
    end else if (load_win_s && (starve_q != SW'(STARVE))) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_mem_store_buffer
// Drives CPU requests, models the 256x8 data memory, and checks the store
// buffer against a queue-based reference model through a scoreboard.
// -----------------------------------------------------------------------------
module tb_mem_store_buffer;
  import mem_sb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int STARVE = 4;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  mem_store_buffer_if #(.AW(8), .DW(8)) bus ();

  mem_store_buffer #(
    .DEPTH  (DEPTH),
    .AW     (8),
    .DW     (8),
    .STARVE (STARVE)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Data memory: combinational read, write at posedge.
  logic [7:0] mem [256] = '{default: 8'h00};
  assign bus.memDataOut = mem[bus.memAddr];
  always @(posedge CLK) begin
    if (bus.memOp) mem[bus.memAddr] <= bus.memDataIn;
  end

  // Reference model: program-order store queue, architectural memory, starvation count.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } st_t;
  st_t        q[$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int         starve = 0;

  typedef struct {
    logic       stall;
    logic       memop;
    logic [7:0] maddr;
    logic [7:0] mdin;
    logic       empty;
    logic       rvalid;
    logic [7:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] model_load(input logic [7:0] a);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == a) return q[i].d;
    end
    return ref_mem[a];
  endfunction

  // One CPU cycle: drive, predict, wait for the edge, advance the model.
  task automatic cycle(input logic ld, input logic st, input logic [7:0] a, input logic [7:0] d);
    bit   fd, lw, pop, full, acc;
    int   n;
    exp_t e;
    bus.ldReq = ld; bus.stReq = st; bus.cpuAddr = a; bus.cpuWdata = d;
    n    = q.size();
    fd   = (starve == STARVE) && (n != 0);
    lw   = ld && !fd;
    pop  = !lw && (n != 0);
    full = (n == DEPTH);
    acc  = st && (!full || pop);
    e.stall  = (st && full && !pop) || (ld && fd);
    e.memop  = pop;
    e.maddr  = a;
    e.mdin   = 8'h00;
    if (pop) begin
      e.maddr = q[0].a;
      e.mdin  = q[0].d;
    end
    e.empty  = (n == 0);
    e.rvalid = ld && !e.stall;
    e.rdata  = model_load(a);
    exp_q.push_back(e);
    @(posedge CLK);
    if (pop) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (acc) q.push_back('{a, d});
    if (n == 0 || pop) starve = 0;
    else if (lw && starve < STARVE) starve++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.ldReq = 1'b0; bus.stReq = 1'b0; bus.cpuAddr = 8'h5A; bus.cpuWdata = 8'h00;
  endtask

  // One reset cycle with idle inputs; memory must not be written meanwhile.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("memop_in_reset", {7'd0, bus.memOp}, 8'h00);
    @(posedge CLK);
    q.delete();
    starve = 0;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_empty", {7'd0, bus.empty}, 8'h01);
    chk("rst_memop", {7'd0, bus.memOp}, 8'h00);
    chk("rst_stall", {7'd0, bus.stall}, 8'h00);
    chk("rst_memaddr", bus.memAddr, 8'h5A);
    chk("rst_memdin", bus.memDataIn, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
    end
    #1;
    chk("drained_empty", {7'd0, bus.empty}, 8'h01);
  endtask

  // Scoreboard monitor: compare every predicted cycle at the falling edge.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", {7'd0, bus.stall}, {7'd0, e.stall});
      chk("memop", {7'd0, bus.memOp}, {7'd0, e.memop});
      chk("memaddr", bus.memAddr, e.maddr);
      chk("memdin", bus.memDataIn, e.mdin);
      chk("empty", {7'd0, bus.empty}, {7'd0, e.empty});
      if (e.rvalid) chk("rdata", bus.cpuRdata, e.rdata);
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // 1: single store drains on the next idle cycle
    cycle(1'b0, 1'b1, 8'h10, 8'hAA);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    chk("t1_mem", mem[8'h10], 8'hAA);
    chk("t1_empty", {7'd0, bus.empty}, 8'h01);

    // 2: forward a buffered store
    cycle(1'b0, 1'b1, 8'h20, 8'h11);
    cycle(1'b1, 1'b0, 8'h20, 8'h00);
    drain();
    chk("t2_mem", mem[8'h20], 8'h11);

    // 3: same address twice, youngest wins
    cycle(1'b0, 1'b1, 8'h30, 8'h01);
    cycle(1'b0, 1'b1, 8'h30, 8'h02);
    cycle(1'b1, 1'b0, 8'h30, 8'h00);
    drain();
    chk("t3_mem", mem[8'h30], 8'h02);

    // 4/5: loads every cycle while stores fill the buffer, forced drain, full push+pop
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, 1'b1, 8'h50 + 8'(i), 8'hC0 + 8'(i));
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 8'h58 + 8'(i), 8'hD0 + 8'(i));
    cycle(1'b0, 1'b1, 8'h60, 8'hE0);
    cycle(1'b1, 1'b1, 8'h61, 8'hE1);
    drain();

    // 6: reset with three stores queued discards them
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'h70 + 8'(i), 8'hF0 + 8'(i));
    do_reset();
    for (int i = 0; i < 3; i++) chk("t6_untouched", mem[8'h70 + 8'(i)], 8'h00);

    // Random traffic over a small address window to exercise forwarding
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 55),
            8'h80 + 8'($urandom_range(0, 7)), 8'($urandom));
    end
    drain();
    for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
